// File: rtl/eth_e2e_csr_bridge.sv
// MMIO front-end of the ETH E2E E10 AFU: host CSR decode, indirect PRMG window
// into the 32-bit E2E register bank, and the E10 Avalon-MM request engine.
//
// state  | meaning
// S_IDLE | no MAC CSR transaction outstanding; E10_CTRL commands accepted
// S_REQ  | e10_read/e10_write held until waitrequest drops or the timer expires
module eth_e2e_csr_bridge #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [63:0] AFU_DFH     = 64'h1000_0000_0000_1000
) (
  input  logic        pClk,
  input  logic        pck_cp2af_softReset,
  input  logic        mmio_rd_valid,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_addr,
  input  logic [1:0]  mmio_len,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        mmio_rsp_valid,
  output logic [8:0]  mmio_rsp_tid,
  output logic [63:0] mmio_rsp_data,
  output logic [3:0]  mac_rst,
  output logic [3:0]  loopback_en,
  input  logic [3:0]  freq_lock,
  input  logic [3:0]  word_lock,
  output logic [1:0]  e10_port,
  output logic [15:0] e10_address,
  output logic        e10_read,
  output logic        e10_write,
  output logic [31:0] e10_writedata,
  input  logic [31:0] e10_readdata,
  input  logic        e10_waitrequest
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic {S_IDLE, S_REQ} e10_state_t;

  e10_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0] prmg_addr_q,  prmg_addr_d;
  logic [31:0] prmg_wdata_q, prmg_wdata_d;
  logic [31:0] prmg_rdata_q, prmg_rdata_d;
  logic [63:0] scratch_q,    scratch_d;
  logic [31:0] e2e_scratch_q, e2e_scratch_d;
  logic [3:0]  mac_rst_q,    mac_rst_d;
  logic [31:0] e10_wdata_q,  e10_wdata_d;
  logic [31:0] e10_rdata_q,  e10_rdata_d;
  logic [1:0]  port_sel_q,   port_sel_d;
  logic [3:0]  loopback_q,   loopback_d;

  logic [1:0]  e10_port_q,  e10_port_d;
  logic [15:0] e10_addr_q,  e10_addr_d;
  logic        e10_wr_q,    e10_wr_d;
  logic [31:0] e10_wout_q,  e10_wout_d;

  logic        s1_valid_q;
  logic [8:0]  s1_tid_q;
  logic [63:0] s1_data_q;
  logic        rsp_valid_q;
  logic [8:0]  rsp_tid_q;
  logic [63:0] rsp_data_q;

  logic        len64, wr_lo, wr_hi;
  logic [14:0] qw;
  logic [31:0] wr_hi_data;
  logic [63:0] rd_qw, rd_word;
  logic        prmg_ctrl_wr, prmg_we, prmg_re, e10_cmd;
  logic [15:0] prmg_idx;

  // 32-bit accesses carry their data in the low DW and target the half picked by addr[0]
  assign len64      = (mmio_len == 2'b10);
  assign qw         = mmio_addr[15:1];
  assign wr_lo      = len64 || !mmio_addr[0];
  assign wr_hi      = len64 || mmio_addr[0];
  assign wr_hi_data = len64 ? mmio_wr_data[63:32] : mmio_wr_data[31:0];

  assign prmg_ctrl_wr = mmio_wr_valid && (qw == 15'd6) && wr_lo;
  assign prmg_idx     = mmio_wr_data[15:0];
  assign prmg_we      = prmg_ctrl_wr && mmio_wr_data[16];
  assign prmg_re      = prmg_ctrl_wr && mmio_wr_data[17] && !mmio_wr_data[16];
  assign e10_cmd      = prmg_we && (prmg_idx == 16'd2) && (prmg_wdata_q[16] || prmg_wdata_q[17]);

  function automatic logic [31:0] e2e_rd(input logic [15:0] idx);
    case (idx)
      16'd0:   e2e_rd = e2e_scratch_q;
      16'd1:   e2e_rd = {28'd0, mac_rst_q};
      16'd2:   e2e_rd = {(state_q != S_IDLE), 31'd0};
      16'd3:   e2e_rd = e10_wdata_q;
      16'd4:   e2e_rd = e10_rdata_q;
      16'd5:   e2e_rd = {30'd0, port_sel_q};
      16'd6:   e2e_rd = {28'd0, loopback_q};
      16'd7:   e2e_rd = {28'd0, freq_lock};
      16'd8:   e2e_rd = {28'd0, word_lock};
      default: e2e_rd = 32'd0;
    endcase
  endfunction

  // Host read decode from current (pre-write) register contents
  always_comb begin
    rd_qw = 64'd0;
    case (qw)
      15'd0:   rd_qw = AFU_DFH;
      15'd6:   rd_qw = {48'd0, prmg_addr_q};
      15'd7:   rd_qw = {32'd0, prmg_wdata_q};
      15'd8:   rd_qw = {32'd0, prmg_rdata_q};
      15'd9:   rd_qw = scratch_q;
      default: rd_qw = 64'd0;
    endcase
    if (len64)               rd_word = rd_qw;
    else if (mmio_addr[0])   rd_word = {2{rd_qw[63:32]}};
    else                     rd_word = {2{rd_qw[31:0]}};
  end

  // Host CSR writes and PRMG window commands into the E2E bank
  always_comb begin
    prmg_addr_d   = prmg_addr_q;
    prmg_wdata_d  = prmg_wdata_q;
    prmg_rdata_d  = prmg_rdata_q;
    scratch_d     = scratch_q;
    e2e_scratch_d = e2e_scratch_q;
    mac_rst_d     = mac_rst_q;
    e10_wdata_d   = e10_wdata_q;
    port_sel_d    = port_sel_q;
    loopback_d    = loopback_q;
    if (mmio_wr_valid) begin
      case (qw)
        15'd6: if (wr_lo) prmg_addr_d  = mmio_wr_data[15:0];
        15'd7: if (wr_lo) prmg_wdata_d = mmio_wr_data[31:0];
        15'd9: begin
          if (wr_lo) scratch_d[31:0]  = mmio_wr_data[31:0];
          if (wr_hi) scratch_d[63:32] = wr_hi_data;
        end
        default: ;
      endcase
    end
    if (prmg_we) begin
      case (prmg_idx)
        16'd0:   e2e_scratch_d = prmg_wdata_q;
        16'd1:   mac_rst_d     = prmg_wdata_q[3:0];
        16'd3:   e10_wdata_d   = prmg_wdata_q;
        16'd5:   port_sel_d    = prmg_wdata_q[1:0];
        16'd6:   loopback_d    = prmg_wdata_q[3:0];
        default: ;
      endcase
    end
    if (prmg_re) prmg_rdata_d = e2e_rd(prmg_idx);
  end

  // E10 request engine: next state, transaction latch and timeout down-counter
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    e10_port_d  = e10_port_q;
    e10_addr_d  = e10_addr_q;
    e10_wr_d    = e10_wr_q;
    e10_wout_d  = e10_wout_q;
    e10_rdata_d = e10_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (e10_cmd) begin
          state_d    = S_REQ;
          cnt_d      = CW'(TIMEOUT_CYC - 1);
          e10_port_d = port_sel_q;
          e10_addr_d = prmg_wdata_q[15:0];
          e10_wr_d   = prmg_wdata_q[16];
          e10_wout_d = e10_wdata_q;
        end
      end
      S_REQ: begin
        if (!e10_waitrequest) begin
          if (!e10_wr_q) e10_rdata_d = e10_readdata;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          e10_rdata_d = 32'hDEAD_BEEF;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) state_q <= S_IDLE;
    else                     state_q <= state_d;
  end

  // Datapath registers and the two-stage read response pipeline
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      cnt_q         <= '0;
      prmg_addr_q   <= '0;
      prmg_wdata_q  <= '0;
      prmg_rdata_q  <= '0;
      scratch_q     <= '0;
      e2e_scratch_q <= '0;
      mac_rst_q     <= 4'hF;
      e10_wdata_q   <= '0;
      e10_rdata_q   <= '0;
      port_sel_q    <= '0;
      loopback_q    <= '0;
      e10_port_q    <= '0;
      e10_addr_q    <= '0;
      e10_wr_q      <= 1'b0;
      e10_wout_q    <= '0;
      s1_valid_q    <= 1'b0;
      s1_tid_q      <= '0;
      s1_data_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tid_q     <= '0;
      rsp_data_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      prmg_addr_q   <= prmg_addr_d;
      prmg_wdata_q  <= prmg_wdata_d;
      prmg_rdata_q  <= prmg_rdata_d;
      scratch_q     <= scratch_d;
      e2e_scratch_q <= e2e_scratch_d;
      mac_rst_q     <= mac_rst_d;
      e10_wdata_q   <= e10_wdata_d;
      e10_rdata_q   <= e10_rdata_d;
      port_sel_q    <= port_sel_d;
      loopback_q    <= loopback_d;
      e10_port_q    <= e10_port_d;
      e10_addr_q    <= e10_addr_d;
      e10_wr_q      <= e10_wr_d;
      e10_wout_q    <= e10_wout_d;
      s1_valid_q    <= mmio_rd_valid;
      s1_tid_q      <= mmio_tid;
      s1_data_q     <= rd_word;
      rsp_valid_q   <= s1_valid_q;
      rsp_tid_q     <= s1_tid_q;
      rsp_data_q    <= s1_data_q;
    end
  end

  // Request strobes decode straight from reset flops so a reset drops them at once
  assign e10_read       = (state_q == S_REQ) && !e10_wr_q;
  assign e10_write      = (state_q == S_REQ) && e10_wr_q;
  assign e10_port       = e10_port_q;
  assign e10_address    = e10_addr_q;
  assign e10_writedata  = e10_wout_q;
  assign mac_rst        = mac_rst_q;
  assign loopback_en    = loopback_q;
  assign mmio_rsp_valid = rsp_valid_q;
  assign mmio_rsp_tid   = rsp_tid_q;
  assign mmio_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_eth_e2e_csr_bridge.sv
// Directed bench for eth_e2e_csr_bridge: MMIO reads are scored through a
// queue, and a small Avalon-MM responder records E10 bus transactions.
module tb_eth_e2e_csr_bridge;

  logic        pClk = 1'b0;
  logic        pck_cp2af_softReset = 1'b1;
  logic        mmio_rd_valid = 1'b0;
  logic        mmio_wr_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [1:0]  mmio_len = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wr_data = '0;
  logic        mmio_rsp_valid;
  logic [8:0]  mmio_rsp_tid;
  logic [63:0] mmio_rsp_data;
  logic [3:0]  mac_rst, loopback_en;
  logic [3:0]  freq_lock = 4'h0;
  logic [3:0]  word_lock = 4'h0;
  logic [1:0]  e10_port;
  logic [15:0] e10_address;
  logic        e10_read, e10_write;
  logic [31:0] e10_writedata;
  logic [31:0] e10_readdata = '0;
  logic        e10_waitrequest = 1'b0;

  eth_e2e_csr_bridge dut (
    .pClk(pClk), .pck_cp2af_softReset(pck_cp2af_softReset),
    .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_len(mmio_len), .mmio_tid(mmio_tid),
    .mmio_wr_data(mmio_wr_data), .mmio_rsp_valid(mmio_rsp_valid),
    .mmio_rsp_tid(mmio_rsp_tid), .mmio_rsp_data(mmio_rsp_data),
    .mac_rst(mac_rst), .loopback_en(loopback_en),
    .freq_lock(freq_lock), .word_lock(word_lock),
    .e10_port(e10_port), .e10_address(e10_address),
    .e10_read(e10_read), .e10_write(e10_write),
    .e10_writedata(e10_writedata), .e10_readdata(e10_readdata),
    .e10_waitrequest(e10_waitrequest)
  );

  initial forever #5 pClk = ~pClk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge pClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  logic [8:0] tid_n = 9'h1A5;

  // Scoreboard: every response pulse must match the oldest outstanding read
  always @(negedge pClk) begin
    if (!pck_cp2af_softReset && mmio_rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_tid", 64'(mmio_rsp_tid), 64'(e.tid));
        chk("rsp_data", mmio_rsp_data, e.data);
        chk("rsp_latency", 64'(cyc), 64'(e.cyc + 2));
      end
    end
  end

  // Avalon-MM responder: hold_req wait cycles per transaction, or stuck forever
  int          hold_req = 0;
  bit          stuck = 1'b0;
  logic [31:0] rd_val = '0;
  int          hold_cnt = 0;
  int          accepts = 0, req_cyc = 0, starts = 0;
  bit          prev_req = 1'b0;
  logic [1:0]  acc_port = '0;
  logic [15:0] acc_addr = '0;
  logic [31:0] acc_data = '0;
  logic        acc_wr = 1'b0;

  always @(negedge pClk) begin
    if (e10_read || e10_write) begin
      req_cyc++;
      if (!prev_req) begin
        starts++;
        hold_cnt = 0;
      end
      if (stuck) begin
        e10_waitrequest = 1'b1;
      end else if (hold_cnt < hold_req) begin
        e10_waitrequest = 1'b1;
        hold_cnt++;
      end else begin
        e10_waitrequest = 1'b0;
        e10_readdata    = rd_val;
        accepts++;
        acc_port = e10_port;
        acc_addr = e10_address;
        acc_data = e10_writedata;
        acc_wr   = e10_write;
      end
      prev_req = 1'b1;
    end else begin
      e10_waitrequest = 1'b0;
      prev_req = 1'b0;
    end
  end

  task automatic drive(input bit rd, input bit wr, input logic [15:0] dw, input logic [1:0] len,
                       input logic [63:0] wd, input logic [63:0] exp);
    @(negedge pClk);
    mmio_rd_valid = rd;
    mmio_wr_valid = wr;
    mmio_addr     = dw;
    mmio_len      = len;
    mmio_tid      = tid_n;
    mmio_wr_data  = wd;
    if (rd) begin
      sb.push_back('{tid: tid_n, data: exp, cyc: cyc});
      tid_n = tid_n + 9'd37;
    end
    @(posedge pClk);
    #1;
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
  endtask

  task automatic wr64(input logic [14:0] q, input logic [63:0] d);
    drive(1'b0, 1'b1, {q, 1'b0}, 2'b10, d, 64'd0);
  endtask
  task automatic rd64(input logic [14:0] q, input logic [63:0] exp);
    drive(1'b1, 1'b0, {q, 1'b0}, 2'b10, 64'd0, exp);
  endtask
  task automatic wr32(input logic [15:0] dw, input logic [31:0] d);
    drive(1'b0, 1'b1, dw, 2'b00, {32'd0, d}, 64'd0);
  endtask
  task automatic rd32(input logic [15:0] dw, input logic [63:0] exp);
    drive(1'b1, 1'b0, dw, 2'b00, 64'd0, exp);
  endtask
  task automatic prmg_wr(input logic [15:0] idx, input logic [31:0] d);
    wr64(15'd7, {32'd0, d});
    wr64(15'd6, {46'd0, 2'b01, idx});
  endtask
  task automatic prmg_rd(input logic [15:0] idx, input logic [31:0] exp);
    wr64(15'd6, {46'd0, 2'b10, idx});
    rd64(15'd8, {32'd0, exp});
  endtask
  task automatic wait_acc(input int base);
    for (int i = 0; i < 100 && accepts == base; i++) @(negedge pClk);
    chk("e10_accept_count", 64'(accepts - base), 64'd1);
    repeat (2) @(negedge pClk);
  endtask

  int b_acc, b_req, b_st;

  initial begin
    repeat (3) @(negedge pClk);
    pck_cp2af_softReset = 1'b0;
    @(negedge pClk);

    chk("rst_mac_rst", 64'(mac_rst), 64'hF);
    chk("rst_loopback", 64'(loopback_en), 64'h0);
    chk("rst_e10_rw", 64'({e10_read, e10_write}), 64'h0);
    chk("rst_e10_addr", 64'({e10_port, e10_address}), 64'h0);
    chk("rst_rsp_valid", 64'(mmio_rsp_valid), 64'h0);

    // Host map, back-to-back pipelined reads
    rd64(15'd0, 64'h1000_0000_0000_1000);
    rd32(16'd1, 64'h1000_0000_1000_0000);
    rd64(15'd3, 64'd0);
    rd64(15'd9, 64'd0);
    wr64(15'd9, 64'hdeefd00fd11fdaaf);
    rd64(15'd9, 64'hdeefd00fd11fdaaf);
    wr32(16'd18, 32'h1122_3344);
    rd64(15'd9, 64'hdeefd00f_11223344);
    wr32(16'd19, 32'hAABB_CCDD);
    rd32(16'd19, 64'hAABBCCDD_AABBCCDD);
    rd32(16'd18, 64'h11223344_11223344);
    drive(1'b1, 1'b1, {15'd9, 1'b0}, 2'b10, 64'h0123_4567_89AB_CDEF, 64'hAABBCCDD_11223344);
    rd64(15'd9, 64'h0123_4567_89AB_CDEF);
    wr64(15'h20, 64'hFFFF_FFFF_FFFF_FFFF);
    rd64(15'h20, 64'd0);

    // PRMG window
    prmg_wr(16'd0, 32'hDAEF_CAFE);
    prmg_rd(16'd0, 32'hDAEF_CAFE);
    prmg_wr(16'd1, 32'h0);
    chk("mac_rst_cleared", 64'(mac_rst), 64'h0);
    prmg_wr(16'd6, 32'hF);
    chk("loopback_set", 64'(loopback_en), 64'hF);
    prmg_rd(16'd6, 32'hF);
    freq_lock = 4'hA;
    word_lock = 4'h5;
    prmg_rd(16'd7, 32'hA);
    prmg_rd(16'd8, 32'h5);
    wr64(15'd7, 64'h1234);
    wr64(15'd6, 64'h3_0000);
    rd64(15'd8, 64'h5);
    wr64(15'd6, 64'h0);
    rd64(15'd8, 64'h5);
    prmg_rd(16'd0, 32'h1234);
    prmg_rd(16'd9, 32'h0);

    // E10 write to port 2 with three waitrequest cycles
    prmg_wr(16'd5, 32'd2);
    prmg_wr(16'd3, 32'd10);
    hold_req = 3;
    b_acc = accepts; b_req = req_cyc; b_st = starts;
    prmg_wr(16'd2, 32'h0001_3C00);
    wait_acc(b_acc);
    chk("e10_wr_port", 64'(acc_port), 64'd2);
    chk("e10_wr_addr", 64'(acc_addr), 64'h3C00);
    chk("e10_wr_data", 64'(acc_data), 64'd10);
    chk("e10_wr_kind", 64'(acc_wr), 64'd1);
    chk("e10_wr_req_cycles", 64'(req_cyc - b_req), 64'd4);
    chk("e10_wr_starts", 64'(starts - b_st), 64'd1);

    // E10 read
    hold_req = 0;
    rd_val = 32'd5;
    b_acc = accepts;
    prmg_wr(16'd2, 32'h0002_1C02);
    wait_acc(b_acc);
    chk("e10_rd_addr", 64'(acc_addr), 64'h1C02);
    chk("e10_rd_kind", 64'(acc_wr), 64'd0);
    prmg_rd(16'd4, 32'd5);

    // Stuck waitrequest: busy flag, dropped second command, timeout abort
    stuck = 1'b1;
    b_acc = accepts; b_req = req_cyc; b_st = starts;
    prmg_wr(16'd2, 32'h0002_0100);
    prmg_rd(16'd2, 32'h8000_0000);
    prmg_wr(16'd2, 32'h0001_0200);
    for (int i = 0; i < 1200 && (e10_read || e10_write); i++) @(negedge pClk);
    chk("timeout_released", 64'({e10_read, e10_write}), 64'd0);
    chk("timeout_req_cycles", 64'(req_cyc - b_req), 64'd1024);
    chk("busy_cmd_dropped", 64'(starts - b_st), 64'd1);
    chk("timeout_no_accept", 64'(accepts - b_acc), 64'd0);
    chk("timeout_addr_kept", 64'(e10_address), 64'h0100);
    prmg_rd(16'd4, 32'hDEAD_BEEF);
    prmg_rd(16'd2, 32'h0);

    // Reset in the middle of a transaction
    prmg_wr(16'd2, 32'h0002_0000);
    @(negedge pClk);
    chk("midrst_req_active", 64'(e10_read), 64'd1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge pClk);
    #2 pck_cp2af_softReset = 1'b1;
    #1;
    chk("midrst_async_drop", 64'({e10_read, e10_write}), 64'd0);
    chk("midrst_mac_rst", 64'(mac_rst), 64'hF);
    @(negedge pClk);
    pck_cp2af_softReset = 1'b0;
    stuck = 1'b0;
    rd64(15'd9, 64'd0);
    rd64(15'd8, 64'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge pClk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
